ps2_key_rx: RTL and testbench

PS/2 keyboard receiver that replaces or parallels the on-board push buttons as the snake game's input source. It samples the keyboard's PS/2 clock and data lines, deframes 11-bit device-to-host frames, and decodes scan-code set 2 make/break sequences into button-style level outputs (`up`, `down`, `right`, `left`, `pause`, `slow`). Those outputs feed the direction, snake and fsm blocks unchanged. Raw bytes are also exported for debug.

---
 rtl/snake_pkg.sv | 74 +++++++
 rtl/ps2_key_rx_frame.sv | 96 +++++++++
 rtl/ps2_key_rx.sv | 71 +++++++
 tb/tb_ps2_key_rx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared encodings for the snake game: directions, game states,
// receiver FSM states and PS/2 scan-code set 2 constants.
package snake_pkg;

   typedef enum logic [1:0] {
      UP    = 2'b00,
      DOWN  = 2'b01,
      RIGHT = 2'b10,
      LEFT  = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      RUNNING = 2'b00,
      DIE     = 2'b01,
      INITIAL = 2'b10
   } game_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } rx_state_t;

   typedef enum logic [2:0] {
      K_UP,
      K_DOWN,
      K_RIGHT,
      K_LEFT,
      K_PAUSE,
      K_SLOW,
      K_NONE
   } key_t;

   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_P     = 8'h4D;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_LEFT  = 8'h6B;

   function automatic key_t key_lookup(input logic ext,
                                       input logic [7:0] code);
      key_t k;
      k = K_NONE;
      if (ext) begin
         case (code)
            SC_UP:    k = K_UP;
            SC_DOWN:  k = K_DOWN;
            SC_RIGHT: k = K_RIGHT;
            SC_LEFT:  k = K_LEFT;
            default:  k = K_NONE;
         endcase
      end else begin
         case (code)
            SC_W:     k = K_UP;
            SC_S:     k = K_DOWN;
            SC_D:     k = K_RIGHT;
            SC_A:     k = K_LEFT;
            SC_P:     k = K_PAUSE;
            SC_SPACE: k = K_SLOW;
            default:  k = K_NONE;
         endcase
      end
      return k;
   endfunction

endpackage

// File: rtl/ps2_key_rx_frame.sv
// PS/2 device-to-host deframer: synchronizers, falling-edge
// detect, 11-bit frame FSM and partial-frame timeout.
module ps2_frame_rx
   import snake_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0] clk_s;
   logic [1:0] data_s;
   logic       clk_prev;
   logic       fall;
   logic       timeout;
   logic       good;
   logic [2:0] cnt_q;
   logic [7:0] shift_q;
   logic       par_q;
   logic [TW-1:0] tcnt_q;
   rx_state_t  state_q;
   rx_state_t  state_d;

   assign fall    = clk_prev & ~clk_s[1];
   assign timeout = (tcnt_q == TW'(TIMEOUT_CYCLES));
   assign good    = data_s[1] & (^shift_q ^ par_q);

   always_comb begin
      state_d = state_q;
      if (timeout) begin
         state_d = S_IDLE;
      end else if (fall) begin
         unique case (state_q)
            S_IDLE:   if (!data_s[1]) state_d = S_DATA;
            S_DATA:   if (cnt_q == 3'd7) state_d = S_PARITY;
            S_PARITY: state_d = S_STOP;
            S_STOP:   state_d = S_IDLE;
         endcase
      end
   end

   // Bus idles high, so synchronizers reset to 1 to avoid a fake edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_s    <= 2'b11;
         data_s   <= 2'b11;
         clk_prev <= 1'b1;
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         tcnt_q   <= '0;
         rx_byte  <= '0;
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
      end else begin
         clk_s    <= {clk_s[0], ps2_clk};
         data_s   <= {data_s[0], ps2_data};
         clk_prev <= clk_s[1];
         state_q  <= state_d;
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         if (fall || state_q == S_IDLE || timeout)
            tcnt_q <= '0;
         else
            tcnt_q <= tcnt_q + 1'b1;
         if (state_q != S_DATA)
            cnt_q <= '0;
         else if (fall)
            cnt_q <= cnt_q + 1'b1;
         if (fall && !timeout) begin
            if (state_q == S_DATA)
               shift_q <= {data_s[1], shift_q[7:1]};
            if (state_q == S_PARITY)
               par_q <= data_s[1];
            if (state_q == S_STOP) begin
               if (good) begin
                  rx_byte  <= shift_q;
                  rx_valid <= 1'b1;
               end else begin
                  rx_err <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard to button-level adapter: decodes set-2 make/break
// sequences into held-key levels for the snake game.
module ps2_key_rx
   import snake_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       up,
   output logic       down,
   output logic       right,
   output logic       left,
   output logic       pause,
   output logic       slow,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_err
);

   logic       ext;
   logic       brk;
   logic [5:0] keys;
   key_t       k;

   ps2_frame_rx #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_frame (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .rx_err   (rx_err)
   );

   assign k = key_lookup(ext, rx_byte);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ext  <= 1'b0;
         brk  <= 1'b0;
         keys <= '0;
      end else if (rx_err) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (rx_valid) begin
         if (rx_byte == SC_EXT) begin
            ext <= 1'b1;
         end else if (rx_byte == SC_BRK) begin
            brk <= 1'b1;
         end else begin
            if (k != K_NONE)
               keys[k] <= !brk;
            ext <= 1'b0;
            brk <= 1'b0;
         end
      end
   end

   assign up    = keys[K_UP];
   assign down  = keys[K_DOWN];
   assign right = keys[K_RIGHT];
   assign left  = keys[K_LEFT];
   assign pause = keys[K_PAUSE];
   assign slow  = keys[K_SLOW];

endmodule

// File: tb/tb_ps2_key_rx.sv
// Bench for ps2_key_rx: directed vector table, corner-case
// sequences and random frames against a key-state model.
module tb_ps2_key_rx;

   localparam int TO   = 100;
   localparam int HALF = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       up, down, right, left, pause, slow;
   logic [7:0] rx_byte;
   logic       rx_valid, rx_err;

   ps2_key_rx #(.TIMEOUT_CYCLES(TO)) dut (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .up       (up),
      .down     (down),
      .right    (right),
      .left     (left),
      .pause    (pause),
      .slow     (slow),
      .rx_byte  (rx_byte),
      .rx_valid (rx_valid),
      .rx_err   (rx_err)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;
   int valid_cnt = 0;
   int err_cnt = 0;
   int wide_cnt = 0;
   logic v_prev = 1'b0;
   logic e_prev = 1'b0;

   always @(negedge clk) begin
      if (rx_valid) valid_cnt <= valid_cnt + 1;
      if (rx_err) err_cnt <= err_cnt + 1;
      if ((rx_valid && v_prev) || (rx_err && e_prev))
         wide_cnt <= wide_cnt + 1;
      v_prev <= rx_valid;
      e_prev <= rx_err;
   end

   // Model: held-key set (bit 5 = up ... bit 0 = slow) and prefixes.
   logic [5:0] m_keys = '0;
   logic [7:0] m_byte = '0;
   bit m_ext = 0;
   bit m_brk = 0;
   int exp_valid = 0;
   int exp_err = 0;

   function automatic int key_pos(bit ext, logic [7:0] code);
      logic [7:0] plain [6];
      logic [7:0] extd [4];
      plain = '{8'h1D, 8'h1B, 8'h23, 8'h1C, 8'h4D, 8'h29};
      extd  = '{8'h75, 8'h72, 8'h74, 8'h6B};
      for (int i = 0; i < 6; i++)
         if (!ext && plain[i] == code) return 5 - i;
      for (int i = 0; i < 4; i++)
         if (ext && extd[i] == code) return 5 - i;
      return -1;
   endfunction

   task automatic model_frame(input logic [7:0] b, input bit perr);
      int p;
      if (perr) begin
         exp_err++;
         m_ext = 0;
         m_brk = 0;
      end else begin
         exp_valid++;
         m_byte = b;
         if (b == 8'hE0) m_ext = 1;
         else if (b == 8'hF0) m_brk = 1;
         else begin
            p = key_pos(m_ext, b);
            if (p >= 0) m_keys[p] = !m_brk;
            m_ext = 0;
            m_brk = 0;
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit perr);
      logic p;
      p = ~^b;
      if (perr) p = ~p;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(p);
      ps2_bit(1'b1);
      repeat (6) @(negedge clk);
      model_frame(b, perr);
   endtask

   function automatic logic [5:0] keys_now();
      return {up, down, right, left, pause, slow};
   endfunction

   typedef struct {
      logic [7:0] b;
      bit         perr;
      logic [5:0] keys;
   } vec_t;

   vec_t tbl[$];
   bit found;
   int v0, e0;
   logic [7:0] last_good;
   logic [7:0] pool [16];

   initial begin
      tbl.push_back('{8'hF0, 0, 6'b100000});
      tbl.push_back('{8'h1D, 0, 6'b000000});
      tbl.push_back('{8'hE0, 0, 6'b000000});
      tbl.push_back('{8'h74, 0, 6'b001000});
      tbl.push_back('{8'hE0, 0, 6'b001000});
      tbl.push_back('{8'hF0, 0, 6'b001000});
      tbl.push_back('{8'h74, 0, 6'b000000});
      tbl.push_back('{8'h74, 0, 6'b000000});
      tbl.push_back('{8'h1D, 1, 6'b000000});
      tbl.push_back('{8'hF0, 0, 6'b000000});
      tbl.push_back('{8'h1D, 1, 6'b000000});
      tbl.push_back('{8'h1D, 0, 6'b100000});
      tbl.push_back('{8'h23, 0, 6'b101000});
      tbl.push_back('{8'h4D, 0, 6'b101010});
      tbl.push_back('{8'h29, 0, 6'b101011});
      tbl.push_back('{8'hE0, 0, 6'b101011});
      tbl.push_back('{8'h72, 0, 6'b111011});
      tbl.push_back('{8'hF0, 0, 6'b111011});
      tbl.push_back('{8'h1D, 0, 6'b011011});
      tbl.push_back('{8'hE0, 0, 6'b011011});
      tbl.push_back('{8'hF0, 0, 6'b011011});
      tbl.push_back('{8'h72, 0, 6'b001011});
      tbl.push_back('{8'h1D, 0, 6'b101011});
      tbl.push_back('{8'h1D, 0, 6'b101011});
      tbl.push_back('{8'hF0, 0, 6'b101011});
      tbl.push_back('{8'h23, 0, 6'b100011});
      tbl.push_back('{8'hF0, 0, 6'b100011});
      tbl.push_back('{8'h4D, 0, 6'b100001});
      tbl.push_back('{8'hF0, 0, 6'b100001});
      tbl.push_back('{8'h29, 0, 6'b100000});
      tbl.push_back('{8'hF0, 0, 6'b100000});
      tbl.push_back('{8'h1D, 0, 6'b000000});

      repeat (5) @(negedge clk);
      chk("reset_keys", 32'(keys_now()), 32'h0);
      chk("reset_byte", 32'(rx_byte), 32'h0);
      chk("reset_pulses", 32'({rx_valid, rx_err}), 32'h0);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      // 1D make: watch rx_valid, then up one cycle later
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(((8'h1D >> i) & 8'h1) != 0);
      ps2_bit(1'b1);
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      found = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rx_valid) begin
            found = 1;
            break;
         end
      end
      chk("lat_valid_seen", 32'(found), 32'h1);
      chk("lat_byte", 32'(rx_byte), 32'h1D);
      chk("lat_up_before", 32'(up), 32'h0);
      @(negedge clk);
      chk("lat_up_after", 32'(up), 32'h1);
      chk("lat_pulse_low", 32'(rx_valid), 32'h0);
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (6) @(negedge clk);
      model_frame(8'h1D, 0);

      last_good = 8'h1D;
      foreach (tbl[i]) begin
         send_frame(tbl[i].b, tbl[i].perr);
         if (!tbl[i].perr) last_good = tbl[i].b;
         chk($sformatf("tbl%0d_keys", i), 32'(keys_now()),
             32'(tbl[i].keys));
         chk($sformatf("tbl%0d_byte", i), 32'(rx_byte),
             32'(last_good));
      end

      // Partial frame abandoned by timeout
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      repeat (TO + 5) @(negedge clk);
      v0 = valid_cnt;
      e0 = err_cnt;
      send_frame(8'h4D, 0);
      chk("timeout_pause", 32'(pause), 32'h1);
      chk("timeout_no_err", 32'(err_cnt), 32'(e0));
      chk("timeout_valid", 32'(valid_cnt), 32'(v0 + 1));

      // Falling edge with data high while idle is not a start bit
      v0 = valid_cnt;
      e0 = err_cnt;
      ps2_bit(1'b1);
      repeat (30) @(negedge clk);
      chk("glitch_pulses", 32'(valid_cnt + err_cnt), 32'(v0 + e0));
      send_frame(8'h1D, 0);
      chk("glitch_next_keys", 32'(keys_now()), 32'(m_keys));
      chk("glitch_next_byte", 32'(rx_byte), 32'h1D);

      // Reset during bit 5 of a frame
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(1'b0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_keys", 32'(keys_now()), 32'h0);
      chk("midrst_byte", 32'(rx_byte), 32'h0);
      rst = 1'b1;
      m_keys = '0;
      m_byte = '0;
      m_ext = 0;
      m_brk = 0;
      repeat (5) @(negedge clk);
      send_frame(8'h29, 0);
      chk("midrst_slow", 32'(keys_now()), 32'h01);

      pool = '{8'h1D, 8'h1B, 8'h23, 8'h1C, 8'h4D, 8'h29, 8'h75, 8'h72,
               8'h74, 8'h6B, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h12, 8'h5A};
      for (int i = 0; i < 60; i++) begin
         logic [7:0] b;
         bit pe;
         b = pool[$urandom_range(0, 15)];
         pe = ($urandom_range(0, 9) == 0);
         send_frame(b, pe);
         chk($sformatf("rnd%0d_keys", i), 32'(keys_now()), 32'(m_keys));
         chk($sformatf("rnd%0d_byte", i), 32'(rx_byte), 32'(m_byte));
      end

      @(negedge clk);
      chk("valid_count", 32'(valid_cnt), 32'(exp_valid));
      chk("err_count", 32'(err_cnt), 32'(exp_err));
      chk("pulse_width", 32'(wide_cnt), 32'h0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
